// File: rtl/hamming_pkg.sv
// Shared constants, counter-width helper and arrival-order type for the Hamming decoder path.
package hamming_pkg;

   localparam int HAM74_W   = 7;
   localparam int HAM1511_W = 15;

   typedef enum logic {
      LSB_FIRST_ARRIVAL = 1'b0,
      MSB_FIRST_ARRIVAL = 1'b1
   } bit_order_e;

   // Width of a counter spanning 0..frame_w-1; never narrower than one bit.
   function automatic int cnt_width(input int frame_w);
      return (frame_w > 1) ? $clog2(frame_w) : 1;
   endfunction

endpackage

// File: rtl/hamming_frame_serial_shift_reg.sv
// Generalised serial-in shifter; arrival order decides which end new bits enter.
module serial_shift_reg #(
   parameter int WIDTH     = 15,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic             d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_next;

   generate
      if (MSB_FIRST) begin : g_msb
         assign q_next = {q[WIDTH-2:0], d};
      end else begin : g_lsb
         assign q_next = {d, q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (en) begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/hamming_frame_deserializer.sv
// Collects FRAME_W serial code bits into a word and presents it through a valid/ready
// output register; the last bit of a frame is loaded straight into frame_out.
module hamming_frame_deserializer
   import hamming_pkg::*;
#(
   parameter int  FRAME_W   = HAM1511_W,
   parameter bit  MSB_FIRST = 1'b0,
   parameter bit  OVERWRITE = 1'b0,
   localparam int CNT_W     = cnt_width(FRAME_W)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               in_ready,
   output logic [FRAME_W-1:0] frame_out,
   output logic               frame_valid,
   input  logic               frame_ready,
   output logic [CNT_W-1:0]   bit_count,
   output logic               overrun
);

   localparam bit_order_e       ORDER    = MSB_FIRST ? MSB_FIRST_ARRIVAL : LSB_FIRST_ARRIVAL;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

   logic [FRAME_W-1:0] shift_q;
   logic [FRAME_W-1:0] word_next;
   logic               last_bit;
   logic               blocked;
   logic               accept;
   logic               complete;
   logic               consume;
   logic               overrun_q;

   serial_shift_reg #(
      .WIDTH     (FRAME_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (accept),
      .d     (in_bit),
      .q     (shift_q)
   );

   // The completing bit is not in shift_q yet, so form the full word alongside it.
   generate
      if (ORDER == MSB_FIRST_ARRIVAL) begin : g_word_msb
         assign word_next = {shift_q[FRAME_W-2:0], in_bit};
      end else begin : g_word_lsb
         assign word_next = {in_bit, shift_q[FRAME_W-1:1]};
      end
   endgenerate

   assign last_bit = (bit_count == LAST_CNT);
   assign blocked  = frame_valid & ~frame_ready;
   assign in_ready = OVERWRITE ? 1'b1 : ~(last_bit & blocked);
   assign accept   = in_valid & in_ready;
   assign complete = accept & last_bit;
   assign consume  = frame_valid & frame_ready;
   assign overrun  = overrun_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_count   <= '0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clear) begin
         bit_count   <= '0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (accept) begin
            bit_count <= last_bit ? '0 : bit_count + CNT_W'(1);
         end
         // A completion wins over a consume so back-to-back frames leave no bubble.
         if (complete) begin
            frame_out   <= word_next;
            frame_valid <= 1'b1;
         end else if (consume) begin
            frame_valid <= 1'b0;
         end
         if (OVERWRITE && complete && blocked) begin
            overrun_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hamming_frame_deserializer.sv
// Directed scoreboard bench: four deserializer builds, expected frames queued by stimulus
// and popped by a monitor on every consume.
module tb_hamming_frame_deserializer;

   logic clk;
   logic reset;
   logic clear;

   logic        a_in_valid, a_in_bit, a_in_ready, a_frame_valid, a_frame_ready, a_overrun;
   logic [14:0] a_frame_out;
   logic [3:0]  a_bit_count;

   logic        bc_in_valid, bc_in_bit, bc_frame_ready;
   logic        b_in_ready, b_frame_valid, b_overrun;
   logic        c_in_ready, c_frame_valid, c_overrun;
   logic [6:0]  b_frame_out, c_frame_out;
   logic [2:0]  b_bit_count, c_bit_count;

   logic        d_in_valid, d_in_bit, d_in_ready, d_frame_valid, d_frame_ready, d_overrun;
   logic [14:0] d_frame_out;
   logic [3:0]  d_bit_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] a_q[$];
   logic [63:0] b_q[$];
   logic [63:0] c_q[$];
   logic [63:0] d_q[$];

   hamming_frame_deserializer #(.FRAME_W(15), .MSB_FIRST(1'b0), .OVERWRITE(1'b0)) u_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(a_in_valid), .in_bit(a_in_bit),
      .in_ready(a_in_ready), .frame_out(a_frame_out), .frame_valid(a_frame_valid),
      .frame_ready(a_frame_ready), .bit_count(a_bit_count), .overrun(a_overrun));

   hamming_frame_deserializer #(.FRAME_W(7), .MSB_FIRST(1'b1), .OVERWRITE(1'b0)) u_b (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(bc_in_valid), .in_bit(bc_in_bit),
      .in_ready(b_in_ready), .frame_out(b_frame_out), .frame_valid(b_frame_valid),
      .frame_ready(bc_frame_ready), .bit_count(b_bit_count), .overrun(b_overrun));

   hamming_frame_deserializer #(.FRAME_W(7), .MSB_FIRST(1'b0), .OVERWRITE(1'b0)) u_c (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(bc_in_valid), .in_bit(bc_in_bit),
      .in_ready(c_in_ready), .frame_out(c_frame_out), .frame_valid(c_frame_valid),
      .frame_ready(bc_frame_ready), .bit_count(c_bit_count), .overrun(c_overrun));

   hamming_frame_deserializer #(.FRAME_W(15), .MSB_FIRST(1'b0), .OVERWRITE(1'b1)) u_d (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(d_in_valid), .in_bit(d_in_bit),
      .in_ready(d_in_ready), .frame_out(d_frame_out), .frame_valid(d_frame_valid),
      .frame_ready(d_frame_ready), .bit_count(d_bit_count), .overrun(d_overrun));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, input logic [63:0] act, inout logic [63:0] q[$]);
      if (q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: unexpected frame 0x%0h with empty scoreboard", name, act);
      end else begin
         chk(name, act, q.pop_front());
      end
   endtask

   // Monitor: every consume handshake must match the oldest expected frame.
   always @(negedge clk) begin
      if (!reset) begin
         if (a_frame_valid && a_frame_ready)   pop_chk("a_frame", 64'(a_frame_out), a_q);
         if (b_frame_valid && bc_frame_ready)  pop_chk("b_frame", 64'(b_frame_out), b_q);
         if (c_frame_valid && bc_frame_ready)  pop_chk("c_frame", 64'(c_frame_out), c_q);
         if (d_frame_valid && d_frame_ready)   pop_chk("d_frame", 64'(d_frame_out), d_q);
      end
   end

   // dut: 0 = a, 1 = b/c pair, 2 = d
   task automatic send_bit(input int dut, input logic b);
      logic acc;
      int   guard;
      acc   = 1'b0;
      guard = 0;
      case (dut)
         0:       begin a_in_valid  = 1'b1; a_in_bit  = b; end
         1:       begin bc_in_valid = 1'b1; bc_in_bit = b; end
         default: begin d_in_valid  = 1'b1; d_in_bit  = b; end
      endcase
      while (!acc && guard < 100) begin
         @(negedge clk);
         case (dut)
            0:       acc = a_in_ready;
            1:       acc = b_in_ready && c_in_ready;
            default: acc = d_in_ready;
         endcase
         @(posedge clk);
         #1;
         guard++;
      end
      case (dut)
         0:       a_in_valid  = 1'b0;
         1:       bc_in_valid = 1'b0;
         default: d_in_valid  = 1'b0;
      endcase
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: dut %0d in_ready stayed 0, required 1 within 100 cycles", dut);
      end
   endtask

   task automatic send_lsb(input int dut, input logic [14:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send_bit(dut, w[i]);
   endtask

   task automatic send_msb7(input logic [6:0] w);
      for (int i = 6; i >= 0; i--) send_bit(1, w[i]);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      n_cmp++;
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clear = 1'b0;
      a_in_valid = 1'b0; a_in_bit = 1'b0; a_frame_ready = 1'b0;
      bc_in_valid = 1'b0; bc_in_bit = 1'b0; bc_frame_ready = 1'b0;
      d_in_valid = 1'b0; d_in_bit = 1'b0; d_frame_ready = 1'b0;
      #23;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_a_valid", 64'(a_frame_valid), 0);
      chk("rst_a_out", 64'(a_frame_out), 0);
      chk("rst_a_count", 64'(a_bit_count), 0);
      chk("rst_a_in_ready", 64'(a_in_ready), 1);
      chk("rst_d_overrun", 64'(d_overrun), 0);

      // Basic 15-bit LSB-first frame, downstream always ready
      a_frame_ready = 1'b1;
      a_q.push_back(64'h2A5B);
      send_lsb(0, 15'h2A5B, 0, 4);
      chk("t1_count_mid", 64'(a_bit_count), 5);
      send_lsb(0, 15'h2A5B, 5, 14);
      chk("t1_valid", 64'(a_frame_valid), 1);
      chk("t1_out", 64'(a_frame_out), 64'h2A5B);
      chk("t1_count_wrap", 64'(a_bit_count), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("t1_valid_cleared", 64'(a_frame_valid), 0);

      // 7-bit frames, MSB-first build vs LSB-first build on the same serial stream
      bc_frame_ready = 1'b1;
      b_q.push_back(64'b1011001);
      c_q.push_back(64'b1001101);
      send_msb7(7'b1011001);
      chk("t2_b_out", 64'(b_frame_out), 64'b1011001);
      chk("t2_c_out", 64'(c_frame_out), 64'b1001101);
      b_q.push_back(64'b0110100);
      c_q.push_back(64'b0010110);
      send_msb7(7'b0110100);

      // Stall only on the final bit of the second frame; no bit lost on release
      a_frame_ready = 1'b0;
      a_q.push_back(64'h1234);
      a_q.push_back(64'h0F0F);
      send_lsb(0, 15'h1234, 0, 14);
      send_lsb(0, 15'h0F0F, 0, 12);
      chk("t3_ready_at13", 64'(a_in_ready), 1);
      send_lsb(0, 15'h0F0F, 13, 13);
      chk("t3_count14", 64'(a_bit_count), 14);
      chk("t3_ready_low", 64'(a_in_ready), 0);
      a_in_valid = 1'b1;
      a_in_bit   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t3_stall_count", 64'(a_bit_count), 14);
      chk("t3_hold_out", 64'(a_frame_out), 64'h1234);
      a_frame_ready = 1'b1;
      send_bit(0, 1'b0);
      chk("t3_no_bubble", 64'(a_frame_valid), 1);
      chk("t3_new_out", 64'(a_frame_out), 64'h0F0F);
      repeat (2) @(posedge clk);
      #1;

      // Completion coincides with consume of the waiting frame, then a streamed third frame
      a_frame_ready = 1'b0;
      a_q.push_back(64'h7AC3);
      a_q.push_back(64'h5555);
      a_q.push_back(64'h0001);
      send_lsb(0, 15'h7AC3, 0, 14);
      send_lsb(0, 15'h5555, 0, 13);
      a_frame_ready = 1'b1;
      send_lsb(0, 15'h5555, 14, 14);
      chk("t5_no_bubble", 64'(a_frame_valid), 1);
      chk("t5_out", 64'(a_frame_out), 64'h5555);
      send_lsb(0, 15'h0001, 0, 14);
      repeat (2) @(posedge clk);
      #1;

      // Overwrite build: second frame replaces the first and overrun sticks
      d_frame_ready = 1'b0;
      send_lsb(2, 15'h1234, 0, 14);
      chk("t4_overrun_first", 64'(d_overrun), 0);
      send_lsb(2, 15'h0F0F, 0, 14);
      chk("t4_out_second", 64'(d_frame_out), 64'h0F0F);
      chk("t4_overrun_set", 64'(d_overrun), 1);
      chk("t4_in_ready", 64'(d_in_ready), 1);
      send_lsb(2, 15'h7FFF, 0, 4);
      chk("t4_overrun_sticky", 64'(d_overrun), 1);
      clear      = 1'b1;
      d_in_valid = 1'b1;
      d_in_bit   = 1'b1;
      @(posedge clk);
      #1;
      clear      = 1'b0;
      d_in_valid = 1'b0;
      chk("t4_clr_overrun", 64'(d_overrun), 0);
      chk("t4_clr_valid", 64'(d_frame_valid), 0);
      chk("t4_clr_count", 64'(d_bit_count), 0);
      chk("t4_clr_out", 64'(d_frame_out), 0);
      d_frame_ready = 1'b1;
      d_q.push_back(64'h2AAA);
      send_lsb(2, 15'h2AAA, 0, 14);
      repeat (2) @(posedge clk);
      #1;

      // Async reset mid-frame with a pending frame
      a_frame_ready = 1'b0;
      a_q.push_back(64'h6DB6);
      send_lsb(0, 15'h6DB6, 0, 14);
      send_lsb(0, 15'h3C3C, 0, 8);
      chk("t6_count9", 64'(a_bit_count), 9);
      chk("t6_pending", 64'(a_frame_valid), 1);
      #1;
      reset = 1'b1;
      a_q.delete();
      #1;
      chk("t6_rst_valid", 64'(a_frame_valid), 0);
      chk("t6_rst_out", 64'(a_frame_out), 0);
      chk("t6_rst_count", 64'(a_bit_count), 0);
      #1;
      reset = 1'b0;
      a_frame_ready = 1'b1;
      a_q.push_back(64'h4321);
      send_lsb(0, 15'h4321, 0, 14);
      chk("t6_fresh_out", 64'(a_frame_out), 64'h4321);
      repeat (4) @(posedge clk);
      #1;

      chk("end_a_q_empty", 64'(a_q.size()), 0);
      chk("end_b_q_empty", 64'(b_q.size()), 0);
      chk("end_c_q_empty", 64'(c_q.size()), 0);
      chk("end_d_q_empty", 64'(d_q.size()), 0);
      chk("end_a_overrun", 64'(a_overrun), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
